// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD subtractor.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W   = 4;
    localparam int unsigned BCD_MAX_DIGIT = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        NEGATE = 2'd2,
        DONE   = 2'd3
    } bcd_state_e;

    // True when a 4-bit code is not a legal BCD digit.
    function automatic logic digit_bad(input logic [BCD_DIGIT_W-1:0] d);
        return d > BCD_DIGIT_W'(BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Combinational single-digit BCD subtract cell: d = x - y - bi, wrapped by +10 on borrow.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] x,
    input  logic [BCD_DIGIT_W-1:0] y,
    input  logic                   bi,
    output logic [BCD_DIGIT_W-1:0] d,
    output logic                   bo
);

    localparam int unsigned T_W = BCD_DIGIT_W + 1;

    logic [T_W-1:0] w_t;
    logic [T_W-1:0] w_t_adj;

    // Range of x-y-bi is [-16, 15], so the 5-bit sign bit is the borrow.
    assign w_t     = {1'b0, x} - {1'b0, y} - T_W'(bi);
    assign w_t_adj = w_t + T_W'(10);
    assign bo      = w_t[T_W-1];
    assign d       = bo ? w_t_adj[BCD_DIGIT_W-1:0] : w_t[BCD_DIGIT_W-1:0];

endmodule

// File: rtl/bcd_serial_sub_ctrl.sv
// Digit-serial multi-digit BCD subtract controller driving one shared digit cell.
// Optional BCD_SIGNMAG_EN adds a NEGATE pass returning sign/magnitude results.
module bcd_serial_sub_ctrl
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
)
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    input  logic                          bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] diff,
    output logic                          bout,
    output logic                          neg,
    output logic                          bad_digit,
    output logic                          busy
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    bcd_state_e r_state;
    bcd_state_e w_state_nxt;

    logic [IDX_W-1:0]                        r_idx;
    logic                                    r_borrow;
    logic [DIGITS-1:0][BCD_DIGIT_W-1:0]      r_a;
    logic [DIGITS-1:0][BCD_DIGIT_W-1:0]      r_b;
    logic [DIGITS-1:0][BCD_DIGIT_W-1:0]      r_diff;
    logic                                    r_bout;
    logic                                    r_neg;
    logic                                    r_bad;
    logic                                    r_in_ready;
    logic                                    r_out_valid;
    logic                                    r_busy;

    logic                   w_accept;
    logic                   w_step;
    logic                   w_last;
    logic                   w_bad_in;
    logic [BCD_DIGIT_W-1:0] w_x;
    logic [BCD_DIGIT_W-1:0] w_y;
    logic                   w_bi;
    logic [BCD_DIGIT_W-1:0] w_d;
    logic                   w_bo;

    assign w_last = (r_idx == IDX_LAST);

    // Any illegal digit in either incoming operand.
    always_comb begin
        w_bad_in = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            w_bad_in = w_bad_in
                     | digit_bad(a[i*BCD_DIGIT_W +: BCD_DIGIT_W])
                     | digit_bad(b[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
        end
    end

    // Operand mux for the shared cell; NEGATE computes 0 - diff.
    always_comb begin
        w_x  = '0;
        w_y  = '0;
        w_bi = r_borrow;
        if (r_state == RUN) begin
            w_x = r_a[r_idx];
            w_y = r_b[r_idx];
        end else if (r_state == NEGATE) begin
            w_y = r_diff[r_idx];
        end
    end

    bcd_digit_sub u_digit_sub (
        .x  (w_x),
        .y  (w_y),
        .bi (w_bi),
        .d  (w_d),
        .bo (w_bo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (w_last) begin
`ifdef BCD_SIGNMAG_EN
                    w_state_nxt = w_bo ? NEGATE : DONE;
`else
                    w_state_nxt = DONE;
`endif
                end
            end
`ifdef BCD_SIGNMAG_EN
            NEGATE: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, per-digit result write-back and final flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_idx    <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_neg    <= 1'b0;
            r_bad    <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_diff   <= '0;
            r_idx    <= '0;
            r_borrow <= bin;
            r_bout   <= 1'b0;
            r_neg    <= 1'b0;
            r_bad    <= w_bad_in;
        end else if (w_step) begin
            r_diff[r_idx] <= w_d;
            r_borrow      <= w_last ? 1'b0 : w_bo;
            r_idx         <= w_last ? '0 : r_idx + IDX_W'(1);
            if (w_last) begin
                if (r_state == RUN) begin
                    r_bout <= w_bo;
                end else begin
`ifdef BCD_SIGNMAG_EN
                    r_neg <= 1'b1;
`else
                    r_neg <= 1'b0;
`endif
                end
            end
        end
    end

    // Handshake/status flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign bad_digit = r_bad;
`ifdef BCD_SIGNMAG_EN
    assign neg       = r_neg;
`else
    assign neg       = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_sub_ctrl.sv
// Self-checking bench for bcd_serial_sub_ctrl: directed table, corner sequences, random ops.
module tb_bcd_serial_sub_ctrl;

    localparam int unsigned D = 4;
    localparam int unsigned W = 4 * D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         bout;
    logic         neg;
    logic         bad_digit;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    bcd_serial_sub_ctrl #(.DIGITS(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .neg       (neg),
        .bad_digit (bad_digit),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] ed;
        logic         eb;
        logic         en;
        logic         ebad;
        bit           chk_diff;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int bcd2int(input logic [W-1:0] x);
        int v;
        logic [3:0] dg;
        v = 0;
        for (int i = D - 1; i >= 0; i--) begin
            dg = x[i*4 +: 4];
            v  = v * 10 + int'(dg);
        end
        return v;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Reference: integer subtraction, then ten's complement or sign/magnitude.
    task automatic model(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bini,
                         output logic [W-1:0] ed, output logic eb, output logic en);
        int r;
        r = bcd2int(ai) - bcd2int(bi) - int'(bini);
        if (r < 0) begin
            eb = 1'b1;
`ifdef BCD_SIGNMAG_EN
            en = 1'b1;
            ed = int2bcd(-r);
`else
            en = 1'b0;
            ed = int2bcd(10 ** D + r);
`endif
        end else begin
            eb = 1'b0;
            en = 1'b0;
            ed = int2bcd(r);
        end
    endtask

    task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bini,
                         input logic [W-1:0] ed, input logic eb, input logic en,
                         input logic ebad, input bit chk_diff, input int hold);
        int n;
        int lat;
        int elat;
        logic [W-1:0] held;
        elat = en ? 2 * D : D;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        a = ai;
        b = bi;
        bin = bini;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("in_ready_after_accept", 32'(in_ready), 32'd0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 4 * D + 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(elat));
        if (chk_diff) begin
            chk("diff", 32'(diff), 32'(ed));
            chk("bout", 32'(bout), 32'(eb));
            chk("neg", 32'(neg), 32'(en));
        end
        chk("bad_digit", 32'(bad_digit), 32'(ebad));
        held = diff;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk);
            #1;
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_diff", 32'(diff), 32'(held));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_after_hs", 32'(out_valid), 32'd0);
        chk("in_ready_after_hs", 32'(in_ready), 32'd1);
        chk("busy_after_hs", 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_diff"}, 32'(diff), 32'd0);
        chk({tag, "_bout"}, 32'(bout), 32'd0);
        chk({tag, "_neg"}, 32'(neg), 32'd0);
        chk({tag, "_bad"}, 32'(bad_digit), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    vec_t tbl[$];

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] red;
        logic         rbin;
        logic         reb;
        logic         ren;

        // Directed vectors: {a, b, bin, diff, bout, neg, bad, check diff}.
        tbl.push_back('{16'h4321, 16'h1234, 1'b0, 16'h3087, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{16'h1000, 16'h0999, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1});
`ifdef BCD_SIGNMAG_EN
        tbl.push_back('{16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{16'h0000, 16'h9999, 1'b0, 16'h9999, 1'b1, 1'b1, 1'b0, 1'b1});
`else
        tbl.push_back('{16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{16'h0000, 16'h0000, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{16'h0000, 16'h9999, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1});
`endif
        tbl.push_back('{16'h9999, 16'h9999, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{16'h5000, 16'h0001, 1'b0, 16'h4999, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{16'h00A0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1});

        #2;
        chk_reset_vals("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_release", 32'(in_ready), 32'd1);

        foreach (tbl[i]) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].ed, tbl[i].eb, tbl[i].en,
                  tbl[i].ebad, tbl[i].chk_diff, 0);
        end

        // Output stall with in_valid pulses ignored.
        do_op(16'h4321, 16'h1234, 1'b0, 16'h3087, 1'b0, 1'b0, 1'b0, 1'b1, 3);

        // Asynchronous reset during RUN discards the partial result.
        a = 16'h9999;
        b = 16'h0001;
        bin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("partial_diff", 32'(diff), 32'h0098);
        chk("partial_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrun_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, 0);

        // Random legal operands against the arithmetic model.
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < D; i++) begin
                ra[i*4 +: 4] = 4'($urandom_range(9));
                rb[i*4 +: 4] = 4'($urandom_range(9));
            end
            rbin = 1'($urandom_range(1));
            model(ra, rb, rbin, red, reb, ren);
            do_op(ra, rb, rbin, red, reb, ren, 1'b0, 1'b1, int'($urandom_range(2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
